// File: rtl/rom_fetch_seq.sv
// Burst read sequencer for a chip-select ROM: strobes CS once per word and
// streams each fetched word downstream over valid/ready with a last-word flag.
module rom_fetch_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    LATCH   = 3'd3,
    PRESENT = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cs_q    <= 1'b1;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cs_d    = 1'b1;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = SETUP;
            addr_d  = start_addr;
            rem_d   = count;
          end else begin
            state_d = FINISH;
          end
        end
      end
      // CS is registered, so it is requested here to be low during STROBE.
      SETUP: begin
        state_d = STROBE;
        cs_d    = 1'b0;
      end
      STROBE: state_d = LATCH;
      LATCH: begin
        data_d  = rom_data;
        valid_d = 1'b1;
        last_d  = (rem_q == CNT_W'(1));
        state_d = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = FINISH;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = SETUP;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign rom_addr  = addr_q;
  assign rom_cs    = cs_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule
